// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - circular obstacle buffer replayed once per frame with player-relative depth
module obstacle_scheduler #(
   parameter int HALF_BLOCK_LENGTH = 64,
   parameter int DEPTH             = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     new_frame,
   input  logic [15:0]              player_score,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               in_type,
   input  logic [1:0]               in_lane,
   input  logic [15:0]              in_pos,
   output logic [15:0]              obstacle,
   output logic                     obstacle_valid,
   output logic                     firstrow,
   output logic                     sweep_done,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [15:0] SPAN     = 16'(2 * HALF_BLOCK_LENGTH);
   localparam logic [AW:0] FULL     = (AW + 1)'(DEPTH);
   localparam logic [15:0] MAX_DEPTH = 16'd2047;

   typedef enum logic {IDLE, SWEEP} state_t;

   // Entry layout: {type[20:18], lane[17:16], pos[15:0]}
   logic [20:0]      mem_q [DEPTH];

   state_t           state_q;
   logic [AW-1:0]    head_q;
   logic [AW-1:0]    tail_q;
   logic [AW-1:0]    idx_q;
   logic [AW:0]      count_q;
   logic [AW:0]      remaining_q;
   logic [15:0]      score_q;
   logic             done_pend_q;
   logic [15:0]      obstacle_q;
   logic             obstacle_valid_q;
   logic             firstrow_q;
   logic             sweep_done_q;

   logic             push;
   logic             retire;
   logic             emit;
   logic [AW-1:0]    cur_idx;
   logic [15:0]      cur_score;
   logic [AW:0]      cur_rem;
   logic [20:0]      cur_entry;
   logic signed [15:0] cur_d;
   logic signed [15:0] head_d;
   logic [10:0]      cur_depth;
   logic             cur_fr;

   // Distance from the player to the far edge of an obstacle, wrapped to signed 16 bits
   function automatic logic signed [15:0] rel_depth(input logic [15:0] pos, input logic [15:0] score);
      return signed'(16'(pos + SPAN - score));
   endfunction

   assign in_ready       = (count_q != FULL);
   assign count          = count_q;
   assign obstacle       = obstacle_q;
   assign obstacle_valid = obstacle_valid_q;
   assign firstrow       = firstrow_q;
   assign sweep_done     = sweep_done_q;

   // Select the entry to emit this cycle; a new frame restarts from head with the fresh score
   always_comb begin
      push      = in_valid && in_ready;
      cur_idx   = new_frame ? head_q       : idx_q;
      cur_score = new_frame ? player_score : score_q;
      cur_rem   = new_frame ? count_q      : remaining_q;
      cur_entry = mem_q[cur_idx];
      emit      = (new_frame || (state_q == SWEEP)) && (cur_rem != '0);
      cur_d     = rel_depth(cur_entry[15:0], cur_score);
      cur_depth = 11'd0;
      cur_fr    = 1'b0;
      if (cur_d > 16'sd0) begin
         cur_depth = (cur_d > signed'(MAX_DEPTH)) ? 11'd2047 : cur_d[10:0];
         cur_fr    = (cur_d <= signed'(SPAN));
      end
      head_d    = rel_depth(mem_q[head_q][15:0], score_q);
      retire    = (state_q == IDLE) && !new_frame && (count_q != '0) && (head_d <= 16'sd0);
   end

   // Entry storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[tail_q] <= {in_type, in_lane, in_pos};
      end
   end

   // Pointers, sweep FSM and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         head_q           <= '0;
         tail_q           <= '0;
         idx_q            <= '0;
         count_q          <= '0;
         remaining_q      <= '0;
         score_q          <= '0;
         done_pend_q      <= 1'b0;
         obstacle_q       <= '0;
         obstacle_valid_q <= 1'b0;
         firstrow_q       <= 1'b0;
         sweep_done_q     <= 1'b0;
      end else begin
         obstacle_valid_q <= 1'b0;
         firstrow_q       <= 1'b0;
         sweep_done_q     <= done_pend_q;
         done_pend_q      <= 1'b0;

         if (push) begin
            tail_q <= tail_q + 1'b1;
         end
         if (retire) begin
            head_q <= head_q + 1'b1;
         end
         unique case ({push, retire})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         if (new_frame) begin
            score_q <= player_score;
         end

         if (emit) begin
            obstacle_q       <= {cur_entry[20:16], cur_depth};
            obstacle_valid_q <= 1'b1;
            firstrow_q       <= cur_fr;
            idx_q            <= cur_idx + 1'b1;
            remaining_q      <= cur_rem - 1'b1;
            if (cur_rem == (AW + 1)'(1)) begin
               state_q     <= IDLE;
               done_pend_q <= 1'b1;
            end else begin
               state_q <= SWEEP;
            end
         end else if (new_frame) begin
            // Empty buffer: the sweep completes immediately
            state_q      <= IDLE;
            sweep_done_q <= 1'b1;
         end
      end
   end

endmodule
